// File: rtl/seg7_scan.sv
// Multi-digit, time-multiplexed common-anode 7-segment driver with hex or
// decimal (sequential double-dabble) display, dots, zero blanking and overflow.
module seg7_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] dado,
  input  logic              load,
  input  logic              modo,
  input  logic              blank_zeros,
  input  logic [DIGITS-1:0] dots,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned NB = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_bin;
  logic [NB-1:0]     r_bcd, r_disp, w_adj, w_bcd_shift, w_hex;
  logic [CW-1:0]     r_cnt;
  logic              r_flag, r_ovf;
  logic [PW-1:0]     r_pre;
  logic [IW-1:0]     r_idx;
  logic [7:0]        r_seg, w_seg_next;
  logic [DIGITS-1:0] r_an, w_lz;
  logic [3:0]        w_digit;
  logic              w_accept, w_last, w_shift_out, w_blank;

  function automatic logic [7:0] f_hex7(input logic [3:0] v);
    case (v)
      4'h0: f_hex7 = 8'hC0;  4'h1: f_hex7 = 8'hF9;
      4'h2: f_hex7 = 8'hA4;  4'h3: f_hex7 = 8'hB0;
      4'h4: f_hex7 = 8'h99;  4'h5: f_hex7 = 8'h92;
      4'h6: f_hex7 = 8'h82;  4'h7: f_hex7 = 8'hF8;
      4'h8: f_hex7 = 8'h80;  4'h9: f_hex7 = 8'h90;
      4'hA: f_hex7 = 8'h88;  4'hB: f_hex7 = 8'h83;
      4'hC: f_hex7 = 8'hC6;  4'hD: f_hex7 = 8'hA1;
      4'hE: f_hex7 = 8'h86;  default: f_hex7 = 8'h8E;
    endcase
  endfunction

  generate
    if (DATA_W >= NB) begin : g_trunc
      assign w_hex = dado[NB-1:0];
    end else begin : g_pad
      assign w_hex = {{(NB-DATA_W){1'b0}}, dado};
    end
  endgenerate

  assign w_accept = load && (r_state == S_IDLE);
  assign w_last   = (r_state == S_CONV) && (r_cnt == CW'(DATA_W - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (load && modo) w_state_next = S_CONV;
      S_CONV: if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Double-dabble step: add 3 to nibbles >= 5, then shift in the binary MSB.
  always_comb begin
    w_adj = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3
                                                    : r_bcd[4*k +: 4];
    end
  end

  assign w_bcd_shift = {w_adj[NB-2:0], r_bin[DATA_W-1]};
  assign w_shift_out = w_adj[NB-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_disp  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        if (modo) begin
          r_bin  <= dado;
          r_bcd  <= '0;
          r_flag <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_disp <= w_hex;
          r_ovf  <= 1'b0;
        end
      end else if (r_state == S_CONV) begin
        r_bin  <= r_bin << 1;
        r_bcd  <= w_bcd_shift;
        r_flag <= r_flag | w_shift_out;
        r_cnt  <= r_cnt + CW'(1);
        if (w_last) begin
          r_disp <= w_bcd_shift;
          r_ovf  <= r_flag | w_shift_out;
        end
      end
    end
  end

  // w_lz[i]: digits i..DIGITS-1 are all zero.
  always_comb begin : lead_zero
    logic        v_zero;
    int unsigned k;
    w_lz   = '0;
    v_zero = 1'b1;
    k      = 0;
    for (int unsigned n = 0; n < DIGITS; n++) begin
      k       = DIGITS - 1 - n;
      v_zero  = v_zero & (r_disp[4*k +: 4] == 4'd0);
      w_lz[k] = v_zero;
    end
  end

  assign w_digit = r_disp[4*r_idx +: 4];
  assign w_blank = blank_zeros && !r_ovf && (r_idx != '0) && w_lz[r_idx];

  always_comb begin
    w_seg_next = f_hex7(w_digit);
    if (r_ovf)        w_seg_next = 8'hBF;
    else if (w_blank) w_seg_next = 8'hFF;
    w_seg_next[7] = ~dots[r_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
      r_seg <= 8'hFF;
      r_an  <= '1;
    end else begin
      if (r_pre == PW'(PRESCALE - 1)) begin
        r_pre <= '0;
        r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      end else begin
        r_pre <= r_pre + PW'(1);
      end
      r_seg <= w_seg_next;
      r_an  <= ~(DIGITS'(1) << r_idx);
    end
  end

  assign seg      = r_seg;
  assign an       = r_an;
  assign busy     = (r_state == S_CONV);
  assign overflow = r_ovf;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: vector table of loads, scoreboard of
// expected per-digit segment codes, plus reset/busy corner sequences.
module tb_seg7_scan;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned PRESCALE = 4;

  logic        clock = 1'b0;
  logic        reset, load, modo, blank_zeros, busy, overflow;
  logic [15:0] dado;
  logic [3:0]  dots, an;
  logic [7:0]  seg;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [7:0] seg;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string       name;
    logic        modo;
    logic [15:0] dado;
    logic        bz;
    logic [3:0]  dots;
    logic [31:0] segs;
    logic        ovf;
  } vec_t;
  vec_t vecs[10];

  seg7_scan #(.DIGITS(DIGITS), .DATA_W(DATA_W), .PRESCALE(PRESCALE)) dut (
    .clock(clock), .reset(reset), .dado(dado), .load(load), .modo(modo),
    .blank_zeros(blank_zeros), .dots(dots), .seg(seg), .an(an),
    .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_digits(input string name, input logic [31:0] segs);
    for (int d = 0; d < 4; d++) begin
      sb_q.push_back('{$sformatf("%s.d%0d", name, d), segs[8*d +: 8]});
    end
  endtask

  task automatic scan_check();
    exp_t       e;
    logic [3:0] exp_an;
    int         t;
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      t = 0;
      while (an !== exp_an && t < 40) begin
        tick();
        t++;
      end
      e = sb_q.pop_front();
      if (an !== exp_an) begin
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for an=%b (got %b)", e.name, exp_an, an);
      end else begin
        chk(e.name, {24'd0, seg}, {24'd0, e.seg});
      end
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int n;
    modo        = v.modo;
    dado        = v.dado;
    blank_zeros = v.bz;
    dots        = v.dots;
    load        = 1'b1;
    push_digits(v.name, v.segs);
    tick();
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk({v.name, ".busy_cycles"}, n, v.modo ? DATA_W : 0);
    chk({v.name, ".overflow"}, {31'd0, overflow}, {31'd0, v.ovf});
    scan_check();
  endtask

  initial begin
    int         n;
    logic [3:0] exp_an;

    vecs[0] = '{"hex1A3F",   1'b0, 16'h1A3F, 1'b0, 4'b0000, 32'hF988B08E, 1'b0};
    vecs[1] = '{"dec1234",   1'b1, 16'd1234, 1'b0, 4'b0000, 32'hF9A4B099, 1'b0};
    vecs[2] = '{"dec10000",  1'b1, 16'd10000, 1'b0, 4'b0000, 32'hBFBFBFBF, 1'b1};
    vecs[3] = '{"dec9999",   1'b1, 16'd9999, 1'b0, 4'b0000, 32'h90909090, 1'b0};
    vecs[4] = '{"dec7_bz",   1'b1, 16'd7,    1'b1, 4'b0100, 32'hFF7FFFF8, 1'b0};
    vecs[5] = '{"dec7_nobz", 1'b1, 16'd7,    1'b0, 4'b0100, 32'hC040C0F8, 1'b0};
    vecs[6] = '{"hex0005_bz", 1'b0, 16'h0005, 1'b1, 4'b0000, 32'hFFFFFF92, 1'b0};
    vecs[7] = '{"hex0_bz_dp", 1'b0, 16'h0000, 1'b1, 4'b1111, 32'h7F7F7F40, 1'b0};
    vecs[8] = '{"dec65535",  1'b1, 16'd65535, 1'b1, 4'b0001, 32'hBFBFBF3F, 1'b1};
    vecs[9] = '{"hexB0DC_bz", 1'b0, 16'hB0DC, 1'b1, 4'b0000, 32'h83C0A1C6, 1'b0};

    reset = 1'b1; load = 1'b0; modo = 1'b0; dado = '0;
    blank_zeros = 1'b0; dots = '0;
    repeat (3) tick();
    chk("reset.seg", {24'd0, seg}, 32'hFF);
    chk("reset.an", {28'd0, an}, 32'hF);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.overflow", {31'd0, overflow}, 32'd0);

    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_an = ~(4'b0001 << ((k / PRESCALE) % DIGITS));
      chk($sformatf("scan.an[%0d]", k), {28'd0, an}, {28'd0, exp_an});
      if (k == 0) chk("scan.first_seg", {24'd0, seg}, 32'hC0);
    end

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Second load during conversion must be ignored.
    blank_zeros = 1'b0; dots = '0;
    modo = 1'b1; dado = 16'd1234; load = 1'b1;
    push_digits("ignore", 32'hF9A4B099);
    tick();
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 3) begin
        load = 1'b1; modo = 1'b0; dado = 16'hFFFF;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    chk("ignore.busy_cycles", n, DATA_W);
    chk("ignore.overflow", {31'd0, overflow}, 32'd0);
    scan_check();

    // Reset mid-conversion, with a load presented alongside reset.
    modo = 1'b1; dado = 16'd9999; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    chk("abort.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1; load = 1'b1; modo = 1'b0; dado = 16'h5555;
    tick();
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.an", {28'd0, an}, 32'hF);
    chk("abort.seg", {24'd0, seg}, 32'hFF);
    chk("abort.overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0; load = 1'b0;
    push_digits("abort", 32'hC0C0C0C0);
    scan_check();
    chk("abort.busy_after", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Parametrised multi-digit 7-segment display driver, the successor of the single-digit hex decoder. It captures a binary value, shows it on DIGITS time-multiplexed common-anode digits in hex or in decimal, and adds per-digit decimal points, leading-zero blanking and overflow indication. Decimal mode uses a sequential double-dabble converter. The block sits between the processor/RAM datapath and the board's 7-segment pins.

## Interface
- DIGITS, 4: number of digits driven.
- DATA_W, 16: width of input value.
- PRESCALE, 50000: clock cycles per digit slot; minimum 2.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- dado  in  DATA_W  value to display; sampled only on load.
- load  in  1  capture strobe, one cycle.
- modo  in  1  sampled with load: 0 = hex, 1 = decimal.
- blank_zeros  in  1  live: 1 = blank leading zeros.
- dots  in  DIGITS  live: 1 = decimal point on for digit i.
- seg  out  8  active-low; seg[6:0] = g..a, seg[7] = dp.
- an  out  DIGITS  active-low digit enables, one-cold.
- busy  out  1  decimal conversion in progress.
- overflow  out  1  last completed decimal load did not fit.

## Operation
- Display register: DIGITS nibbles, digit 0 least significant. Reset value is 0.
- Hex load (modo=0, busy=0): nibble i = dado[4i+3:4i]. Bits above DATA_W are zero-filled; bits beyond 4*DIGITS are dropped. overflow is cleared.
- Decimal load (modo=1, busy=0): dado is captured into a shift register and the BCD accumulator is cleared.
  - One double-dabble step per cycle, DATA_W steps in total: add 3 to every BCD nibble ≥ 5, then shift left 1 with the binary MSB entering BCD bit 0.
  - Any 1 shifted out of BCD bit 4*DIGITS-1 sets a sticky overflow flag.
  - On the last step the BCD result goes to the display register and overflow is set from the flag.
  - If the flag is set, every digit shows '-' instead.
- A load while busy=1 is ignored and has no side effect.
- Scan:
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - On wrap, the digit index advances 0→1→…→DIGITS-1→0.
  - an = ~(1 << index).
- Segment codes with dp off, seg[7:0], hex: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. Dash BF, blank FF.
- dp: seg[7] = ~dots[index]. It applies to blank and dash digits too.
- Blanking: digit i (i ≥ 1) is blank when blank_zeros=1 and digits i..DIGITS-1 are all zero. Digit 0 is never blanked. Blanking is not applied in the overflow/dash state.

## Timing
- Reset values: seg=FF, an=all ones, busy=0, overflow=0, index=0, prescaler=0, display=0.
- seg and an are registered and reflect index, display, dots and blank_zeros from the previous cycle. The first cycle after reset release drives an=~1 and seg=C0 (FF if dots[0]=0 is irrelevant: dp off gives C0).
- Hex: load at cycle n, display updated at n+1, visible on the pins at n+2 when digit i is being scanned; busy stays 0.
- Decimal: load at cycle n, busy=1 during cycles n+1..n+DATA_W, display and overflow updated at n+DATA_W+1, busy=0 in the same cycle. A new load is accepted at n+DATA_W+1.
- The old display stays shown throughout a conversion, so there is no partial-result flicker.
- Scanning never stops for a load or a conversion.
- Reset mid-conversion aborts it; all state returns to reset values next cycle.
- load and reset together: reset wins.

## Test plan
- Reset, PRESCALE=4, DIGITS=4 → seg=FF, an=1111 during reset. After release, an goes 1110, 1101, 1011, 0111, each for 4 cycles, then wraps.
- Hex load dado=16'h1A3F, blank_zeros=0 → scanned seg sequence 8E, B0, 88, F9 for digits 0..3; busy never 1.
- Decimal load dado=16'd1234 → busy high exactly 16 cycles; digits 0..3 show 99, B0, A4, F9; overflow=0.
- Decimal load dado=16'd10000 → overflow=1 and all digits BF. Then decimal load 9999 → overflow=0 and all digits 90.
- Decimal load dado=16'd7, blank_zeros=1, dots=4'b0100 → digit 0 F8, digits 1 and 3 FF, digit 2 7F. With blank_zeros=0, digits 1..3 show C0 (digit 2 shows 40).
- Second load during busy → ignored, first result shown. Reset asserted mid-conversion → busy=0, display 0 next cycle.
